div64by32_seq: RTL and testbench

//  Sequential unsigned divider: 2W-bit dividend / W-bit divisor -> W-bit quotient + W-bit remainder.

---
 rtl/div64by32_seq.sv | 157 +++++++++++++++
 tb/tb_div64by32_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div64by32_seq.sv
// div64by32_seq: sequential unsigned divider, 2W-bit dividend by W-bit divisor.
// Restoring radix-2 datapath producing one quotient bit per DIV cycle.
// Handshake: start is a request that is only honoured in IDLE (the accepting
// edge latches a/b); busy covers CHECK, DIV and DONE; done is a one-cycle pulse
// in DONE, and the registered results/flags are valid from that cycle until
// the next accepted start. There is no back-pressure and no request queuing.
module div64by32_seq #(
   parameter int W = 32
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [2*W-1:0] a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [W-1:0]   quotient,
   output logic [W-1:0]   remainder,
   output logic           div_by_zero,
   output logic           overflow,
   output logic [1:0]     dbg_state
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      DIV   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t         state;
   state_t         state_next;
   logic           accept;

   logic [2*W-1:0] a_r;
   logic [W-1:0]   b_r;
   logic [W-1:0]   rem;
   logic [W-1:0]   qsh;
   logic [CW-1:0]  cnt;

   logic [W:0]     trial;
   logic           trial_ge;
   logic [W-1:0]   diff;
   logic [W-1:0]   rem_next;
   logic [W-1:0]   qsh_next;

   assign dbg_state = state;

   // One restoring step: shift in the next dividend bit and try to subtract.
   // rem < b_r always holds, so when trial >= b_r the difference fits in W bits
   // and the low W bits of a W-bit subtraction are exact.
   always_comb begin
      trial    = {rem, qsh[W-1]};
      trial_ge = (trial >= {1'b0, b_r});
      diff     = trial[W-1:0] - b_r;
      rem_next = trial_ge ? diff : trial[W-1:0];
      qsh_next = {qsh[W-2:0], trial_ge};
   end

   // State register; asynchronous reset abandons any operation in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state decode plus busy/done, which follow the state directly.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = CHECK;
            end
         end
         CHECK: begin
            busy = 1'b1;
            if (b_r == '0 || a_r[2*W-1:W] >= b_r) state_next = DONE;
            else                                  state_next = DIV;
         end
         DIV: begin
            busy = 1'b1;
            if (cnt == '0) state_next = DONE;
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand capture, error screening, iteration and result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_r         <= '0;
         b_r         <= '0;
         rem         <= '0;
         qsh         <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_r         <= a;
                  b_r         <= b;
                  rem         <= '0;
                  qsh         <= '0;
                  cnt         <= '0;
                  quotient    <= '0;
                  remainder   <= '0;
                  div_by_zero <= 1'b0;
                  overflow    <= 1'b0;
               end
            end
            CHECK: begin
               if (b_r == '0) begin
                  div_by_zero <= 1'b1;
                  quotient    <= '1;
                  remainder   <= a_r[W-1:0];
               end else if (a_r[2*W-1:W] >= b_r) begin
                  // High half already >= divisor: quotient cannot fit in W bits.
                  overflow    <= 1'b1;
                  quotient    <= '1;
                  remainder   <= '0;
               end else begin
                  rem <= a_r[2*W-1:W];
                  qsh <= a_r[W-1:0];
                  cnt <= CW'(W - 1);
               end
            end
            DIV: begin
               rem <= rem_next;
               qsh <= qsh_next;
               if (cnt == '0) begin
                  quotient  <= qsh_next;
                  remainder <= rem_next;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div64by32_seq.sv
// tb_div64by32_seq: directed and random checks for div64by32_seq.
// Expected results are pushed to exp_q when an operation is started and
// popped when done is observed. Inputs change and outputs are sampled on the
// falling edge. Latency is counted in cycles after the accepting edge, the
// done cycle included (W+2 for a full divide, 2 for an error case).
module tb_div64by32_seq;

   localparam int W  = 32;
   localparam int EW = 2 * W + 2;

   logic           clk;
   logic           reset;
   logic           start;
   logic [2*W-1:0] a;
   logic [W-1:0]   b;
   logic           busy;
   logic           done;
   logic [W-1:0]   quotient;
   logic [W-1:0]   remainder;
   logic           div_by_zero;
   logic           overflow;
   logic [1:0]     dbg_state;

   int checks = 0;
   int errors = 0;
   logic [EW-1:0] exp_q[$];

   div64by32_seq #(.W(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow),
      .dbg_state   (dbg_state)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packs {div_by_zero, overflow, quotient, remainder}.
   function automatic logic [EW-1:0] pack(input logic dz, input logic ov,
                                          input logic [W-1:0] q, input logic [W-1:0] r);
      return {dz, ov, q, r};
   endfunction

   // Reference model built on the language's own 2W-bit divide.
   function automatic logic [EW-1:0] model(input logic [2*W-1:0] av, input logic [W-1:0] bv);
      logic [2*W-1:0] bw;
      logic [2*W-1:0] q64;
      logic [2*W-1:0] r64;
      if (bv == '0) return pack(1'b1, 1'b0, '1, av[W-1:0]);
      if (av[2*W-1:W] >= bv) return pack(1'b0, 1'b1, '1, '0);
      bw  = {{W{1'b0}}, bv};
      q64 = av / bw;
      r64 = av % bw;
      return pack(1'b0, 1'b0, q64[W-1:0], r64[W-1:0]);
   endfunction

   // Driver: called on a falling edge in IDLE; one-cycle start pulse, then
   // operands are scrambled to show they are not used after the accept.
   task automatic start_op(input logic [2*W-1:0] av, input logic [W-1:0] bv,
                           input logic [EW-1:0] exp_v);
      exp_q.push_back(exp_v);
      a     = av;
      b     = bv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = {$urandom, $urandom};
      b     = $urandom;
   endtask

   // Scoreboard side: waits (bounded) for done, checks busy, latency and the
   // result, then steps into the following IDLE cycle and checks it.
   task automatic wait_result(input int exp_lat, input int first_cyc, input string name);
      int            cyc;
      bit            seen;
      bit            busy_bad;
      logic [EW-1:0] exp_v;
      logic [EW-1:0] got_v;
      cyc      = first_cyc;
      seen     = 1'b0;
      busy_bad = 1'b0;
      while (!seen && cyc <= first_cyc + 200) begin
         if (busy !== 1'b1) busy_bad = 1'b1;
         if (done === 1'b1) seen = 1'b1;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
      checks++;
      if (busy_bad) begin
         errors++;
         $display("FAIL %s busy: busy dropped before done", name);
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s timeout: no done within %0d cycles", name, 200);
      end else if (cyc != exp_lat) begin
         errors++;
         $display("FAIL %s latency: got %0d expected %0d", name, cyc, exp_lat);
      end
      if (seen) begin
         checks++;
         got_v = pack(div_by_zero, overflow, quotient, remainder);
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s result: got %h with no expectation queued", name, got_v);
         end else begin
            exp_v = exp_q.pop_front();
            if (got_v !== exp_v) begin
               errors++;
               $display("FAIL %s result: got dz=%b ov=%b q=%h r=%h expected dz=%b ov=%b q=%h r=%h",
                        name, got_v[EW-1], got_v[EW-2], got_v[2*W-1:W], got_v[W-1:0],
                        exp_v[EW-1], exp_v[EW-2], exp_v[2*W-1:W], exp_v[W-1:0]);
            end
         end
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL %s idle_after: got busy=%b done=%b expected 0 0", name, busy, done);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      @(negedge clk);
      checks++;
      if ({busy, done, div_by_zero, overflow, quotient, remainder, dbg_state} !== '0) begin
         errors++;
         $display("FAIL reset_state: got busy=%b done=%b dz=%b ov=%b q=%h r=%h st=%0d expected all 0",
                  busy, done, div_by_zero, overflow, quotient, remainder, dbg_state);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_start: got busy=%b done=%b expected 0 0", busy, done);
      end
   endtask

   task automatic test_basic();
      start_op(64'd100, 32'd7, pack(1'b0, 1'b0, 32'd14, 32'd2));
      wait_result(W + 2, 1, "div_100_7");
      start_op(64'h0000_0001_2345_6789, 32'd0, pack(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h2345_6789));
      wait_result(2, 1, "div_by_zero");
      start_op(64'h0000_0005_0000_0000, 32'd5, pack(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0));
      wait_result(2, 1, "overflow");
      start_op(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, pack(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0));
      wait_result(W + 2, 1, "max_quotient");
      start_op(64'd0, 32'd1, pack(1'b0, 1'b0, 32'd0, 32'd0));
      wait_result(W + 2, 1, "zero_dividend");
      start_op(64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF,
               pack(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE));
      wait_result(W + 2, 1, "max_remainder");
      start_op(64'h0000_0001_0000_0000, 32'd1, pack(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0));
      wait_result(2, 1, "overflow_b1");
   endtask

   task automatic test_random();
      logic [2*W-1:0] av;
      logic [W-1:0]   bv;
      logic [W-1:0]   hi;
      bit             bad;
      int             nbad;
      nbad = 0;
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 3) == 0) bv = W'($urandom_range(1, 255));
         else                           bv = $urandom;
         if (bv == '0) bv = 32'd1;
         hi = $urandom % bv;
         av = {hi, 32'($urandom)};
         start_op(av, bv, model(av, bv));
         wait_result(W + 2, 1, "random");
         bad = ({{W{1'b0}}, quotient} * {{W{1'b0}}, bv} + {{W{1'b0}}, remainder} != av)
               || (remainder >= bv);
         checks++;
         if (bad) begin
            errors++;
            nbad++;
            if (nbad <= 5)
               $display("FAIL random_identity: a=%h b=%h got q=%h r=%h", av, bv, quotient, remainder);
         end
      end
   endtask

   task automatic test_ignored_start();
      bit extra_done;
      start_op(64'd1000, 32'd3, pack(1'b0, 1'b0, 32'd333, 32'd1));
      repeat (10) @(negedge clk);
      checks++;
      if (dbg_state !== 2'd2) begin
         errors++;
         $display("FAIL ignored_start_state: got %0d expected 2", dbg_state);
      end
      a     = 64'd999;
      b     = 32'd10;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_result(W + 2, 12, "ignored_start");
      extra_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1 || busy === 1'b1) extra_done = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (extra_done) begin
         errors++;
         $display("FAIL ignored_start_queued: got a second operation expected none");
      end
   endtask

   task automatic test_back_to_back();
      exp_q.push_back(pack(1'b0, 1'b0, 32'd15, 32'd2));
      a     = 64'd77;
      b     = 32'd5;
      start = 1'b1;
      @(negedge clk);
      // start stays high; these operands belong to the next operation
      exp_q.push_back(pack(1'b0, 1'b0, 32'd142, 32'd6));
      a = 64'd1000;
      b = 32'd7;
      wait_result(W + 2, 1, "b2b_first");
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || dbg_state !== 2'd1) begin
         errors++;
         $display("FAIL b2b_accept: got busy=%b st=%0d expected 1 1", busy, dbg_state);
      end
      wait_result(W + 2, 1, "b2b_second");
   endtask

   task automatic test_mid_reset();
      bit saw_done;
      start_op(64'd1000000, 32'd3, pack(1'b0, 1'b0, 32'd333333, 32'd1));
      repeat (20) @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 ||
          dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL mid_reset: got busy=%b done=%b q=%h r=%h st=%0d expected 0",
                  busy, done, quotient, remainder, dbg_state);
      end
      exp_q.delete();
      @(negedge clk);
      reset    = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         errors++;
         $display("FAIL mid_reset_done: got done after abandoned op expected none");
      end
      start_op(64'd50, 32'd6, pack(1'b0, 1'b0, 32'd8, 32'd2));
      wait_result(W + 2, 1, "after_reset");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_random();
      test_ignored_start();
      test_back_to_back();
      test_mid_reset();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
